// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - big-endian byte-lane data memory with registered loads and misalignment trap
// Optional post-reset zero sweep built when DMEM_CLEAR_EN is defined.
module dmem_bytelane #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] data_o,
  output logic        err
);

  localparam int WORDS = 1 << (ADDR_W - 2);
  localparam int IDX_W = ADDR_W - 2;

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {S_RST, S_CLEAR, S_IDLE} state_t;
`else
  typedef enum logic [1:0] {S_RST, S_IDLE} state_t;
`endif

  state_t            state, state_nx;
  logic [31:0]       mem [WORDS];
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              mis;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [31:0]       rshift;
  logic [15:0]       rhalf;
  logic [31:0]       ldata;
  logic              unused_addr;

  assign idx         = addr[ADDR_W-1:2];
  assign unused_addr = ^addr[31:ADDR_W];
  assign accept      = ce && ready;

  always_comb begin
    mis = 1'b0;
    case (size)
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
  end

  // wmask bit b enables word bits [8b+7:8b]; byte offset 0 is the top lane.
  always_comb begin
    wmask = 4'b0000;
    wdata = data_i;
    case (size)
      2'b00: begin
        wdata = {4{data_i[7:0]}};
        wmask = 4'b1000 >> addr[1:0];
      end
      2'b01: begin
        wdata = {2{data_i[15:0]}};
        wmask = addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
    if (mis) wmask = 4'b0000;
  end

  always_comb begin
    rword  = mem[idx];
    rshift = rword >> {~addr[1:0], 3'b000};
    rhalf  = addr[1] ? rword[15:0] : rword[31:16];
    ldata  = 32'h0;
    case (size)
      2'b00:   ldata = {{24{sext & rshift[7]}}, rshift[7:0]};
      2'b01:   ldata = {{16{sext & rhalf[15]}}, rhalf};
      2'b10:   ldata = rword;
      default: ldata = 32'h0;
    endcase
    if (mis) ldata = 32'h0;
  end

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 clr_cnt <= '0;
    else if (state == S_CLEAR)  clr_cnt <= clr_cnt + 1'b1;
    else                        clr_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
`ifdef DMEM_CLEAR_EN
      S_RST:   state_nx = S_CLEAR;
      S_CLEAR: if (&clr_cnt) state_nx = S_IDLE;
`else
      S_RST:   state_nx = S_IDLE;
`endif
      S_IDLE:  ready = 1'b1;
      default: state_nx = S_RST;
    endcase
  end

  // Array has no reset; the sweep is the only way it is zeroed.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (state == S_CLEAR) mem[clr_cnt] <= 32'h0;
    else
`endif
    if (accept && we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      data_o <= 32'h0;
    end else begin
      rvalid <= accept && !we;
      err    <= accept && mis;
      if (accept && !we) data_o <= ldata;
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - scoreboard bench for dmem_bytelane
// Expectations for the sweep follow DMEM_CLEAR_EN as seen by the bench.
module tb_dmem_bytelane;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic        ready, rvalid, err;
  logic [31:0] data_o;

  typedef struct {
    int          due;
    logic        rv;
    logic        er;
    logic [31:0] d;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b1;

  dmem_bytelane #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .size(size), .sext(sext),
    .addr(addr), .data_i(data_i), .ready(ready), .rvalid(rvalid),
    .data_o(data_o), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_rvalid"}, 32'(rvalid), 32'(e.rv));
        chk({e.tag, "_err"}, 32'(err), 32'(e.er));
        if (e.rv) chk({e.tag, "_data"}, data_o, e.d);
      end else if (rvalid || err) begin
        chk("spurious_rvalid_err", {30'h0, rvalid, err}, 32'h0);
      end
    end
  end

  task automatic req(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_err, input string tag);
    exp_t e;
    @(posedge clk); #1;
    ce = 1'b1; we = w; size = sz; sext = sx; addr = a; data_i = wd;
    e.due = cyc + 1; e.rv = !w; e.er = exp_err; e.d = exp_d; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ce = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_and_wait();
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef DMEM_CLEAR_EN
    for (int k = 1; k <= 257; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        ce = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
      end
      if (k == 6) ce = 1'b0;
      if (k == 1 || k == 256) chk("clr_busy_ready", 32'(ready), 32'h0);
      if (k == 257) chk("clr_done_ready", 32'(ready), 32'h1);
    end
`else
    @(posedge clk); #1;
    chk("first_edge_ready", 32'(ready), 32'h1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_data", data_o, 32'h0);

    release_and_wait();
`ifdef DMEM_CLEAR_EN
    req(0, 2'b10, 0, 32'h10, 0, 32'h0, 0, "clr_word_10");
`endif
    // lane mapping
    req(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, "st_word_20");
    req(0, 2'b00, 0, 32'h21, 0, 32'h00000022, 0, "ld_byte_21");
    req(0, 2'b01, 0, 32'h22, 0, 32'h00003344, 0, "ld_half_22");
    req(0, 2'b10, 0, 32'h20, 0, 32'h11223344, 0, "ld_word_20");
    req(0, 2'b00, 0, 32'h20, 0, 32'h00000011, 0, "ld_byte_20");
    req(0, 2'b01, 1, 32'h20, 0, 32'h00001122, 0, "ld_half_20_sx");
    // extension
    req(1, 2'b00, 0, 32'h23, 32'hAAAAAA80, 0, 0, "st_byte_23");
    req(0, 2'b00, 1, 32'h23, 0, 32'hFFFFFF80, 0, "ld_byte_23_sx");
    req(0, 2'b00, 0, 32'h23, 0, 32'h00000080, 0, "ld_byte_23_zx");
    req(0, 2'b10, 1, 32'h20, 0, 32'h11223380, 0, "ld_word_20_b");
    // misalignment
    req(0, 2'b10, 0, 32'h22, 0, 32'h0, 1, "mis_ld_word_22");
    req(1, 2'b01, 0, 32'h21, 32'h0000BEEF, 0, 1, "mis_st_half_21");
    req(0, 2'b10, 0, 32'h20, 0, 32'h11223380, 0, "ld_word_20_c");
    req(0, 2'b11, 0, 32'h20, 0, 32'h0, 1, "mis_ld_size3");
    req(1, 2'b11, 0, 32'h20, 32'h0, 0, 1, "mis_st_size3");
    req(0, 2'b10, 0, 32'h20, 0, 32'h11223380, 0, "ld_word_20_d");
    // back-to-back and throughput
    req(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 0, 0, "st_word_40");
    req(0, 2'b10, 0, 32'h40, 0, 32'hDEADBEEF, 0, "b2b_ld_40");
    req(1, 2'b01, 0, 32'h22, 32'h12345566, 0, 0, "st_half_22");
    req(0, 2'b10, 0, 32'h20, 0, 32'h11225566, 0, "ld_word_20_e");
    req(0, 2'b00, 1, 32'h41, 0, 32'hFFFFFFAD, 0, "ld_byte_41_sx");
    req(0, 2'b01, 1, 32'h42, 0, 32'hFFFFBEEF, 0, "ld_half_42_sx");
    req(0, 2'b01, 0, 32'h40, 0, 32'h0000DEAD, 0, "ld_half_40_zx");
    req(1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 0, 0, "st_word_3fc");
    req(0, 2'b10, 0, 32'h13FC, 0, 32'hCAFEF00D, 0, "ld_word_wrap");
    idle();
    @(posedge clk); #1;
    chk("hold_data", data_o, 32'hCAFEF00D);
    chk("hold_rvalid", 32'(rvalid), 32'h0);
    chk("queue_drained_1", 32'(q.size()), 32'h0);

    // reset with a load result on the outputs
    mon_en = 1'b0;
    ce = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40;
    @(posedge clk); #1;
    ce = 1'b0;
    chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    chk("pre_rst_data", data_o, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready), 32'h0);
    chk("async_rst_rvalid", 32'(rvalid), 32'h0);
    chk("async_rst_data", data_o, 32'h0);
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

`ifdef DMEM_CLEAR_EN
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midclr_ready", 32'(ready), 32'h0);
    chk("midclr_rvalid", 32'(rvalid), 32'h0);
    chk("midclr_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    release_and_wait();
    req(0, 2'b10, 0, 32'h3FC, 0, 32'h0, 0, "reclr_ld_3fc");
    req(0, 2'b10, 0, 32'h40, 0, 32'h0, 0, "reclr_ld_40");
`else
    release_and_wait();
    req(0, 2'b10, 0, 32'h3FC, 0, 32'hCAFEF00D, 0, "kept_ld_3fc");
`endif
    idle();
    chk("queue_drained_2", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised byte-lane data memory for the CPU's MEM stage. It supports byte, halfword and word loads and stores with big-endian lane ordering and optional sign extension on loads. Loads are registered with a valid strobe, misaligned accesses are trapped, and an optional post-reset clear sweep zeroes the array before the pipeline is admitted. It sits between the MEM-stage load/store unit and the exception logic, and replaces the unsized byte-array RAM.

## Interface
Parameters:
- ADDR_W, 10, byte-address bits decoded. Capacity is 2^ADDR_W bytes, organised as WORDS = 2^(ADDR_W-2) words of 4 lanes. Legal range 4..16.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous reset, active low
- ce  in  1  request valid
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address; bits above ADDR_W-1 ignored (wraps)
- data_i  in  32  store data, right-aligned: byte in [7:0], half in [15:0]
- ready  out  1  block accepts requests
- rvalid  out  1  load result valid
- data_o  out  32  load result, right-aligned and extended
- err  out  1  misaligned or illegal-size request

## Operation
- A request is accepted on a rising edge where ce && ready. Requests seen while ready=0 are dropped: no write, no rvalid, no err.
- Lane mapping is big-endian. Byte offset 0 is word bits [31:24] and offset 3 is bits [7:0]. Halfword offset 0 is [31:16] and offset 2 is [15:0].
- Misaligned requests are:
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]≠0;
  - size=11.
- Store: writes only the addressed lanes with the low bytes of data_i. A misaligned store writes nothing.
- Load: selects the addressed lanes, right-aligns them, then zero- or sign-extends per sext (sext is ignored for word loads).
- Misaligned load: returns data_o=0.
- State machine:
  - RST: entered while rst_n=0.
  - CLEAR: a word counter runs 0..WORDS-1 and writes zero to every lane; ready=0.
  - IDLE: ready=1.
  - RST→CLEAR on the first edge after rst_n deasserts. CLEAR→IDLE after the write of word WORDS-1.
- Reset mid-operation:
  - All outputs clear immediately and any pending load result is lost.
  - A reset during CLEAR aborts the sweep; after release the sweep restarts at word 0.
  - Array contents are not reset asynchronously.

## Timing
- Reset values: ready=0, rvalid=0, data_o=0, err=0. The clear counter resets to 0.
- Load latency is 1 cycle. rvalid and data_o update on the edge following acceptance, and rvalid stays high for exactly one cycle per load.
- When no load completes, data_o holds its last value.
- Store takes effect at the accepting edge. A load accepted on the next edge returns the new data, so store→load back-to-back needs no stall.
- One request can be accepted per cycle at full throughput. Consecutive loads produce rvalid on consecutive cycles.
- err is registered and pulses for one cycle, one cycle after a misaligned request. For a misaligned load, rvalid=1 in the same cycle as err, with data_o=0. For a misaligned store, err pulses and rvalid stays 0.
- With clear enabled, ready rises WORDS+1 cycles after rst_n deasserts.

## Configuration
- DMEM_CLEAR_EN defined: the CLEAR state and sweep counter are built, and power-up contents read as zero.
- DMEM_CLEAR_EN undefined: there is no CLEAR state and RST→IDLE directly. ready rises on the first edge after rst_n deasserts. Array contents are undefined until written.

## Test plan
- Clear sweep (ADDR_W=10, DMEM_CLEAR_EN): release reset → ready=0 for 256 cycles, then 1 on cycle 257. Word load at 0x10 → rvalid=1, data_o=0x00000000 next cycle.
- Lane mapping: word store 0x11223344 @0x20, then:
  - byte load @0x21 → 0x00000022;
  - half load @0x22 → 0x00003344;
  - word load @0x20 → 0x11223344.
- Extension: byte store 0x80 @0x23, then:
  - byte load sext=1 → 0xFFFFFF80;
  - byte load sext=0 → 0x00000080;
  - word load @0x20 → 0x11223380.
- Misalignment:
  - word load @0x22 → err=1, rvalid=1, data_o=0;
  - half store 0xBEEF @0x21 → err=1, rvalid=0, and a following word load @0x20 is unchanged;
  - size=11 load → err=1.
- Back-to-back: store 0xDEADBEEF @0x40 then load @0x40 next cycle → data_o=0xDEADBEEF one cycle later. Four consecutive loads → four consecutive rvalid pulses.
- Reset mid-clear: assert rst_n=0 at sweep cycle 100 → ready, rvalid and err go 0 immediately. After release, ready stays 0 for a full 256 cycles again, and a word load @0x3FC then reads 0.
